pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives the 2-bit control
//  input of every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB) and PC write-enable.
//  Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
//  Keeps saturating stall/flush event counters and flags memory timeouts.
//  Stage-control encoding: 0 = PASS (load In), 1 = HOLD (keep Out), 2 = BUBBLE (zero, MemToReg=1).
// PARAMETERS
//  MEM_TIMEOUT  64  max consecutive MEM_WAIT cycles before MemError; range 1..2^16-1
//  CNT_W        16  width of StallCycles / FlushCount
// PORTS
//  Clock          in   1      pipeline clock; all state updates on posedge
//  Reset_n        in   1      asynchronous, active-low reset
//  ID_EX_MemRead  in   1      instruction in EX is a load
//  ID_EX_Rt       in   5      destination register of that load
//  IF_ID_Rs       in   5      source register Rs of instruction in ID
//  IF_ID_Rt       in   5      source register Rt of instruction in ID
//  BranchTaken    in   1      branch/jump resolved taken in EX this cycle
//  MemReq         in   1      instruction in MEM issues a load or store
//  MemReady       in   1      data memory completes the access this cycle
//  PCWrite        out  1      1 = PC loads next value
//  IF_ID_Signal   out  2      control for IF_ID register
//  ID_EX_Signal   out  2      control for ID_EX register
//  EX_MEM_Signal  out  2      control for EX_MEM register
//  MEM_WB_Signal  out  2      control for MEM_WB register
//  MemError       out  1      sticky; set on MEM_TIMEOUT expiry
//  StallCycles    out  CNT_W  saturating count of cycles with PCWrite=0
//  FlushCount     out  CNT_W  saturating count of branch flushes
// BEHAVIOUR
//  - Reset (Reset_n=0, async): state=RUN, wait counter=0, MemError=0, counters=0.
//    While in reset, outputs are forced: PCWrite=0, all four Signals=2.
//  - States: RUN, MEM_WAIT. Registered state; outputs combinational from state and inputs,
//    consumed by pipeline registers at the next posedge.
//  - RUN, priority high->low:
//    1. MemReq & !MemReady: PCWrite=0; IF_ID/ID_EX/EX_MEM=1; MEM_WB=2; next=MEM_WAIT; wait cnt=1.
//    2. BranchTaken: PCWrite=1; IF_ID=2; ID_EX=2; EX_MEM=0; MEM_WB=0; FlushCount++.
//    3. Load-use: ID_EX_MemRead & ID_EX_Rt!=0 & (ID_EX_Rt==IF_ID_Rs | ID_EX_Rt==IF_ID_Rt):
//       PCWrite=0; IF_ID=1; ID_EX=2; EX_MEM=0; MEM_WB=0. Exactly one bubble; the next
//       cycle re-evaluates (the bubble clears MemRead, so the hazard does not repeat).
//    4. Otherwise: PCWrite=1; all Signals=0.
//  - MEM_WAIT: outputs as RUN case 1; BranchTaken and load-use are ignored (EX is frozen,
//    condition is re-seen after release). Wait counter increments each cycle.
//    MemReady=1: that cycle outputs are RUN case 4 (all pass, PCWrite=1); next=RUN.
//    Wait counter reaching MEM_TIMEOUT without MemReady: set MemError; next=RUN;
//    that cycle MEM_WB=2, others 0, PCWrite=1 (access dropped).
//  - MemReady in the same cycle as MemReq in RUN: no stall, normal priority from case 2.
//  - StallCycles increments every non-reset cycle with PCWrite=0; both counters saturate
//    at 2^CNT_W-1 and never wrap. MemError is cleared only by reset.
//  - Reset asserted mid-MEM_WAIT: immediate return to RUN with reset outputs; no partial state.
// TESTING
//  - Reset release, no hazards, 10 cycles -> PCWrite=1, all Signals=0, StallCycles=0.
//  - ID_EX_MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 -> one cycle IF_ID=1, ID_EX=2, PCWrite=0;
//    StallCycles=1. Same with ID_EX_Rt=0 -> no stall.
//  - BranchTaken=1 and load-use together -> IF_ID=2, ID_EX=2, PCWrite=1; FlushCount=1.
//  - MemReq=1, MemReady low 3 cycles, then high -> 3 stalled cycles (1,1,1,2, PCWrite=0),
//    release cycle all 0; StallCycles=3; BranchTaken pulsed during wait ignored.
//  - MEM_TIMEOUT=4, MemReady never -> MemError=1 on 4th wait cycle, state returns to RUN.
//  - Reset_n dropped mid-MEM_WAIT -> outputs forced to 2/PCWrite=0 immediately;
//    after release, RUN with all counters 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: drives the pipeline-register controls and
// PC write-enable, resolves load-use, branch-flush and data-memory wait hazards.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic [1:0]       IF_ID_Signal,
  output logic [1:0]       ID_EX_Signal,
  output logic [1:0]       EX_MEM_Signal,
  output logic [1:0]       MEM_WB_Signal,
  output logic             MemError,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  localparam logic [1:0] PASS   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] BUBBLE = 2'd2;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t            stateReg, stateNext;
  logic [WAIT_W-1:0] waitCntReg, waitCntNext;
  logic              memErrorReg;
  logic [CNT_W-1:0]  stallCntReg, flushCntReg;

  logic       memStall, loadUse, timeoutNow, flushNow;
  logic       pcWriteC;
  logic [1:0] ifIdC, idExC, exMemC, memWbC;

  assign memStall   = MemReq && !MemReady;
  assign loadUse    = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));
  // The entering cycle already counts as one stalled cycle, so the counter holds
  // the number of stalled cycles spent on the pending access.
  assign timeoutNow = (stateReg == MEM_WAIT) && !MemReady && (waitCntReg == TIMEOUT_V);

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      stateReg   <= RUN;
      waitCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext   = stateReg;
    waitCntNext = waitCntReg;
    case (stateReg)
      RUN: begin
        if (memStall) begin
          stateNext   = MEM_WAIT;
          waitCntNext = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReady || timeoutNow) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else begin
          waitCntNext = waitCntReg + WAIT_W'(1);
        end
      end
      default: begin
        stateNext   = RUN;
        waitCntNext = '0;
      end
    endcase
  end

  // Output logic (before reset forcing)
  always_comb begin
    pcWriteC = 1'b1;
    ifIdC    = PASS;
    idExC    = PASS;
    exMemC   = PASS;
    memWbC   = PASS;
    flushNow = 1'b0;
    case (stateReg)
      RUN: begin
        if (memStall) begin
          pcWriteC = 1'b0;
          ifIdC    = HOLD;
          idExC    = HOLD;
          exMemC   = HOLD;
          memWbC   = BUBBLE;
        end else if (BranchTaken) begin
          ifIdC    = BUBBLE;
          idExC    = BUBBLE;
          flushNow = 1'b1;
        end else if (loadUse) begin
          pcWriteC = 1'b0;
          ifIdC    = HOLD;
          idExC    = BUBBLE;
        end
      end
      MEM_WAIT: begin
        if (timeoutNow) begin
          memWbC = BUBBLE;
        end else if (!MemReady) begin
          pcWriteC = 1'b0;
          ifIdC    = HOLD;
          idExC    = HOLD;
          exMemC   = HOLD;
          memWbC   = BUBBLE;
        end
      end
      default: begin
        pcWriteC = 1'b1;
      end
    endcase
  end

  // Event counters and sticky timeout flag
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      memErrorReg <= 1'b0;
      stallCntReg <= '0;
      flushCntReg <= '0;
    end else begin
      if (timeoutNow)
        memErrorReg <= 1'b1;
      if (!pcWriteC && (stallCntReg != '1))
        stallCntReg <= stallCntReg + CNT_W'(1);
      if (flushNow && (flushCntReg != '1))
        flushCntReg <= flushCntReg + CNT_W'(1);
    end
  end

  assign PCWrite       = Reset_n ? pcWriteC : 1'b0;
  assign IF_ID_Signal  = Reset_n ? ifIdC    : BUBBLE;
  assign ID_EX_Signal  = Reset_n ? idExC    : BUBBLE;
  assign EX_MEM_Signal = Reset_n ? exMemC   : BUBBLE;
  assign MEM_WB_Signal = Reset_n ? memWbC   : BUBBLE;
  assign MemError      = memErrorReg | timeoutNow;
  assign StallCycles   = stallCntReg;
  assign FlushCount    = flushCntReg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and randomized checks of pipeline_hazard_controller against a cycle-level
// behavioural model of the hazard rules.
module tb_pipeline_hazard_controller;

  localparam int TO   = 4;
  localparam int CW   = 5;
  localparam int MAXC = (1 << CW) - 1;

  // {PCWrite, IF_ID, ID_EX, EX_MEM, MEM_WB}
  localparam logic [8:0] PASSV   = 9'b1_00_00_00_00;
  localparam logic [8:0] STALLV  = 9'b0_01_01_01_10;
  localparam logic [8:0] FLUSHV  = 9'b1_10_10_00_00;
  localparam logic [8:0] LUV     = 9'b0_01_10_00_00;
  localparam logic [8:0] TMOV    = 9'b1_00_00_00_10;
  localparam logic [8:0] FORCEDV = 9'b0_10_10_10_10;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          ID_EX_MemRead = 1'b0;
  logic [4:0]    ID_EX_Rt = '0, IF_ID_Rs = '0, IF_ID_Rt = '0;
  logic          BranchTaken = 1'b0, MemReq = 1'b0, MemReady = 1'b0;
  logic          PCWrite, MemError;
  logic [1:0]    IF_ID_Signal, ID_EX_Signal, EX_MEM_Signal, MEM_WB_Signal;
  logic [CW-1:0] StallCycles, FlushCount;
  logic [8:0]    obsCtl;

  int checks = 0;
  int errors = 0;

  // Reference model: pending-access flag, stalled cycles spent on it, sticky error, counters
  bit mWait = 0;
  int mWaited = 0;
  bit mErr = 0;
  int mStall = 0;
  int mFlush = 0;

  pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .BranchTaken(BranchTaken), .MemReq(MemReq), .MemReady(MemReady),
    .PCWrite(PCWrite), .IF_ID_Signal(IF_ID_Signal), .ID_EX_Signal(ID_EX_Signal),
    .EX_MEM_Signal(EX_MEM_Signal), .MEM_WB_Signal(MEM_WB_Signal),
    .MemError(MemError), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  always #10 Clock = ~Clock;

  assign obsCtl = {PCWrite, IF_ID_Signal, ID_EX_Signal, EX_MEM_Signal, MEM_WB_Signal};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mWait = 0; mWaited = 0; mErr = 0; mStall = 0; mFlush = 0;
  endtask

  // One pipeline cycle: drive after the falling edge, compare, then advance the model.
  task automatic cycle(input string tag, input bit rstn, input bit mr, input logic [4:0] exRt,
                       input logic [4:0] rs, input logic [4:0] rt, input bit br,
                       input bit mq, input bit mrdy);
    logic [8:0] expCtl;
    bit tmo, flush;
    @(negedge Clock);
    Reset_n = rstn; ID_EX_MemRead = mr; ID_EX_Rt = exRt; IF_ID_Rs = rs; IF_ID_Rt = rt;
    BranchTaken = br; MemReq = mq; MemReady = mrdy;
    #1;
    tmo = 0; flush = 0;
    if (!rstn) begin
      modelReset();
      expCtl = FORCEDV;
    end else if (mWait) begin
      if (mrdy)              expCtl = PASSV;
      else if (mWaited >= TO) begin expCtl = TMOV; tmo = 1; end
      else                   expCtl = STALLV;
    end else if (mq && !mrdy) expCtl = STALLV;
    else if (br) begin expCtl = FLUSHV; flush = 1; end
    else if (mr && exRt != 0 && (exRt == rs || exRt == rt)) expCtl = LUV;
    else expCtl = PASSV;
    $display("cyc %s rstn=%0b mr=%0b rt=%0d rs=%0d rt=%0d br=%0b mq=%0b rdy=%0b ctl=%09b exp=%09b stall=%0d flush=%0d err=%0b",
             tag, rstn, mr, exRt, rs, rt, br, mq, mrdy, obsCtl, expCtl, StallCycles, FlushCount, MemError);
    check({tag, "_ctl"}, 32'(obsCtl), 32'(expCtl));
    check({tag, "_err"}, 32'(MemError), 32'(mErr | tmo));
    check({tag, "_stallcnt"}, 32'(StallCycles), 32'(mStall));
    check({tag, "_flushcnt"}, 32'(FlushCount), 32'(mFlush));
    if (rstn) begin
      if (!expCtl[8]) mStall = (mStall < MAXC) ? mStall + 1 : MAXC;
      if (flush)      mFlush = (mFlush < MAXC) ? mFlush + 1 : MAXC;
      if (tmo)        mErr = 1;
      if (mWait) begin
        if (mrdy || tmo) begin mWait = 0; mWaited = 0; end
        else mWaited++;
      end else if (mq && !mrdy) begin
        mWait = 1; mWaited = 1;
      end
    end
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cycle("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("reset", 0, 1, 3, 3, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) idle("idle");
    check("idle_pcwrite", 32'(PCWrite), 32'd1);
    check("idle_stallcnt", 32'(StallCycles), 32'd0);

    cycle("loaduse", 1, 1, 5, 5, 0, 0, 0, 0);
    check("loaduse_ctl", 32'(obsCtl), 32'(LUV));
    idle("after_lu");
    check("lu_stallcnt", 32'(StallCycles), 32'd1);
    cycle("lu_r0", 1, 1, 0, 0, 0, 0, 0, 0);
    check("lu_r0_pcwrite", 32'(PCWrite), 32'd1);
    cycle("lu_rt", 1, 1, 9, 1, 9, 0, 0, 0);

    cycle("br_lu", 1, 1, 7, 7, 0, 1, 0, 0);
    check("br_lu_ctl", 32'(obsCtl), 32'(FLUSHV));
    idle("after_br");
    check("br_flushcnt", 32'(FlushCount), 32'd1);

    cycle("memw", 1, 0, 0, 0, 0, 0, 1, 0);
    check("memw_ctl", 32'(obsCtl), 32'(STALLV));
    cycle("memw_br", 1, 1, 4, 4, 0, 1, 1, 0);
    cycle("memw", 1, 0, 0, 0, 0, 0, 1, 0);
    cycle("memrel", 1, 0, 0, 0, 0, 0, 1, 1);
    check("memrel_ctl", 32'(obsCtl), 32'(PASSV));
    idle("after_mem");
    check("mem_stallcnt", 32'(StallCycles), 32'd5);
    check("mem_flushcnt", 32'(FlushCount), 32'd1);

    cycle("memrdy_same", 1, 0, 0, 0, 0, 1, 1, 1);

    for (int i = 0; i < TO + 1; i++) cycle("tmo", 1, 0, 0, 0, 0, 0, 1, 0);
    check("tmo_err", 32'(MemError), 32'd1);
    check("tmo_ctl", 32'(obsCtl), 32'(TMOV));
    idle("after_tmo");
    check("tmo_sticky", 32'(MemError), 32'd1);

    cycle("midw", 1, 0, 0, 0, 0, 0, 1, 0);
    cycle("midw", 1, 0, 0, 0, 0, 0, 1, 0);
    #2 Reset_n = 1'b0;
    #1;
    check("midrst_ctl", 32'(obsCtl), 32'(FORCEDV));
    check("midrst_stallcnt", 32'(StallCycles), 32'd0);
    check("midrst_err", 32'(MemError), 32'd0);
    #2 Reset_n = 1'b1; MemReq = 1'b0;
    #1;
    check("midrst_run_ctl", 32'(obsCtl), 32'(PASSV));
    modelReset();
    idle("after_midrst");

    for (int i = 0; i < MAXC + 6; i++) cycle("sat_lu", 1, 1, 3, 0, 3, 0, 0, 0);
    check("sat_stallcnt", 32'(StallCycles), 32'(MAXC));
    for (int i = 0; i < MAXC + 6; i++) cycle("sat_br", 1, 0, 0, 0, 0, 1, 0, 0);
    check("sat_flushcnt", 32'(FlushCount), 32'(MAXC));

    cycle("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      cycle("rand", ($urandom_range(199) != 0), ($urandom_range(2) == 0),
            5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
            ($urandom_range(4) == 0), ($urandom_range(2) == 0), ($urandom_range(3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
